// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: op codes, instruction field
// positions, FSM encodings and a small decode helper.
package alu_seq_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 3;

  // Op codes carried in instruction bits [31:28]
  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_EQ  = 4'h3;
  localparam logic [3:0] OP_GT  = 4'h4;
  localparam logic [3:0] OP_LI  = 4'hE;

  // Instruction field positions; bits [18:16] are reserved
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 25;
  localparam int RS1_MSB = 24;
  localparam int RS1_LSB = 22;
  localparam int RS2_MSB = 21;
  localparam int RS2_LSB = 19;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [15:0]       imm;
  } instr_t;

  function automatic instr_t decode(input logic [XLEN-1:0] w);
    instr_t d;
    d.op  = w[OP_MSB:OP_LSB];
    d.rd  = w[RD_MSB:RD_LSB];
    d.rs1 = w[RS1_MSB:RS1_LSB];
    d.rs2 = w[RS2_MSB:RS2_LSB];
    d.imm = w[IMM_MSB:IMM_LSB];
    return d;
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op <= OP_GT);
  endfunction

endpackage

// File: rtl/alu32.sv
// Registered 32-bit ALU driven by the sequencer: y is updated one clock
// edge after f/a/b are sampled. EQ and GT produce zero-extended 1-bit results.
module alu32
  import alu_seq_pkg::*;
(
  input  logic            clk,
  input  logic [3:0]      f,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  logic [XLEN:0] w_diff_ba;

  // Signed a > b is the sign of the overflow-free (b - a)
  assign w_diff_ba = {b[XLEN-1], b} - {a[XLEN-1], a};

  // Result register
  always_ff @(posedge clk) begin
    case (f)
      OP_AND:  y <= a & b;
      OP_OR:   y <= a | b;
      OP_SUB:  y <= a - b;
      OP_EQ:   y <= {{(XLEN-1){1'b0}}, (a == b)};
      OP_GT:   y <= {{(XLEN-1){1'b0}}, w_diff_ba[XLEN]};
      default: y <= '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_regfile.sv
// 8x32 register file: two combinational read ports, a debug read port and
// one write port. R0 is never written and always reads as zero.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [XLEN-1:0]   o_rdata1,
  output logic [XLEN-1:0]   o_rdata2,
  output logic [XLEN-1:0]   o_dbg_data
);

  logic [XLEN-1:0] r_regs [NREGS];

  // Register storage: cleared on reset, writes to R0 are discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read ports: R0 decodes to a constant zero
  always_comb begin
    o_rdata1   = (i_raddr1   == '0) ? '0 : r_regs[i_raddr1];
    o_rdata2   = (i_raddr2   == '0) ? '0 : r_regs[i_raddr2];
    o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];
  end

endmodule

// File: rtl/alu_sequencer.sv
// Single-issue sequencer: accepts one instruction in IDLE, issues ALU ops to
// an external registered ALU, and writes results back to a local register
// file. Accepting only in IDLE makes back-to-back dependencies safe.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_instr,
  output logic [3:0]        alu_f,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  input  logic [XLEN-1:0]   alu_y,
  output logic              done,
  output logic [REG_AW-1:0] done_rd,
  output logic [XLEN-1:0]   done_data,
  output logic              err,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  state_t              r_state;
  state_t              w_next;
  instr_t              w_dec;
  logic                w_accept;
  logic                w_is_alu;
  logic                w_is_li;
  logic                w_we;
  logic [XLEN-1:0]     w_rdata1;
  logic [XLEN-1:0]     w_rdata2;

  logic [REG_AW-1:0]   r_rd;
  logic [15:0]         r_imm;
  logic                r_is_li;
  logic                r_err;
  logic [3:0]          r_alu_f;
  logic [XLEN-1:0]     r_alu_a;
  logic [XLEN-1:0]     r_alu_b;

  assign w_dec    = decode(in_instr);
  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_is_alu = is_alu_op(w_dec.op);
  assign w_is_li  = (w_dec.op == OP_LI);
  assign w_we     = (r_state == ST_WB);

  alu_seq_regfile #(
    .NREGS (NREGS)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst),
    .i_we       (w_we),
    .i_waddr    (r_rd),
    .i_wdata    (done_data),
    .i_raddr1   (w_dec.rs1),
    .i_raddr2   (w_dec.rs2),
    .i_dbg_addr (dbg_addr),
    .o_rdata1   (w_rdata1),
    .o_rdata2   (w_rdata2),
    .o_dbg_data (dbg_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next state: ALU ops go through ISSUE, LI goes straight to writeback,
  // illegal ops leave the FSM in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_alu)     w_next = ST_ISSUE;
        else if (w_accept && w_is_li) w_next = ST_WB;
      end
      ST_ISSUE: w_next = ST_WB;
      ST_WB:    w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Capture destination and immediate of every legal accepted instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd    <= '0;
      r_imm   <= '0;
      r_is_li <= 1'b0;
    end else if (w_accept && (w_is_alu || w_is_li)) begin
      r_rd    <= w_dec.rd;
      r_imm   <= w_dec.imm;
      r_is_li <= w_is_li;
    end
  end

  // ALU operand registers: loaded only by an accepted ALU op, so they hold
  // their last-issued values otherwise and never carry an op above GT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_f <= '0;
      r_alu_a <= '0;
      r_alu_b <= '0;
    end else if (w_accept && w_is_alu) begin
      r_alu_f <= w_dec.op;
      r_alu_a <= w_rdata1;
      r_alu_b <= w_rdata2;
    end
  end

  // One-cycle error pulse for a dropped illegal op
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else      r_err <= w_accept && !w_is_alu && !w_is_li;
  end

  // Handshake and writeback outputs, all zero outside WB
  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    done      = 1'b0;
    done_rd   = '0;
    done_data = '0;
    if (r_state == ST_WB) begin
      done      = 1'b1;
      done_rd   = r_rd;
      done_data = r_is_li ? {16'b0, r_imm} : alu_y;
    end
  end

  assign alu_f = r_alu_f;
  assign alu_a = r_alu_a;
  assign alu_b = r_alu_b;
  assign err   = r_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer paired with alu32.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [3:0]  alu_f;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic        done;
  logic [2:0]  done_rd;
  logic [31:0] done_data;
  logic        err;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.NREGS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .alu_f     (alu_f),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y),
    .done      (done),
    .done_rd   (done_rd),
    .done_data (done_data),
    .err       (err),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  alu32 u_alu (
    .clk (clk),
    .f   (alu_f),
    .a   (alu_a),
    .b   (alu_b),
    .y   (alu_y)
  );

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [15:0] imm);
    return {op, rd, rs1, rs2, 3'b000, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // LI: done in the cycle after acceptance, register visible one cycle later
  task automatic run_li(input string tag, input logic [2:0] rd, input logic [15:0] imm);
    @(negedge clk);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_instr = mk(4'hE, rd, 3'd0, 3'd0, imm);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_instr = '0;
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_rd"}, 32'(done_rd), 32'(rd));
    check({tag, "_data"}, done_data, {16'b0, imm});
    @(negedge clk);
    check({tag, "_done_off"}, 32'(done), 32'd0);
    check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  // ALU op: ISSUE in cycle k+1, done in k+2; optionally holds a competing
  // LI R7 on the input through ISSUE and WB, which must be ignored
  task automatic run_alu(input string tag, input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] ey, input bit junk);
    @(negedge clk);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_instr = mk(op, rd, rs1, rs2, 16'h0000);
    @(posedge clk);
    #1;
    if (junk) begin
      in_instr = mk(4'hE, 3'd7, 3'd0, 3'd0, 16'hBEEF);
    end else begin
      in_valid = 1'b0;
      in_instr = '0;
    end
    @(negedge clk);
    check({tag, "_f"}, 32'(alu_f), 32'(op));
    check({tag, "_a"}, alu_a, ea);
    check({tag, "_b"}, alu_b, eb);
    check({tag, "_issue_rdy"}, 32'(in_ready), 32'd0);
    check({tag, "_issue_done"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_rd"}, 32'(done_rd), 32'(rd));
    check({tag, "_data"}, done_data, ey);
    check({tag, "_wb_rdy"}, 32'(in_ready), 32'd0);
    check({tag, "_wb_f_hold"}, 32'(alu_f), 32'(op));
    in_valid = 1'b0;
    in_instr = '0;
    @(negedge clk);
    check({tag, "_done_off"}, 32'(done), 32'd0);
    check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dcnt;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    dbg_addr = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_rdy", 32'(in_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_f", 32'(alu_f), 32'd0);
    check("rst_a", alu_a, 32'd0);
    check("rst_b", alu_b, 32'd0);
    check("rst_rd", 32'(done_rd), 32'd0);
    check("rst_data", done_data, 32'd0);
    rd_reg("rst_r1", 3'd1, 32'd0);
    rst = 1'b1;
    #1;
    check("rel_rdy", 32'(in_ready), 32'd1);

    // Load immediates
    run_li("li1", 3'd1, 16'h0005);
    rd_reg("r1_eq5", 3'd1, 32'd5);
    run_li("li2", 3'd2, 16'h0003);
    rd_reg("r2_eq3", 3'd2, 32'd3);

    // ALU ops, read-after-write back to back
    run_alu("sub", 4'h2, 3'd3, 3'd1, 3'd2, 32'd5, 32'd3, 32'd2, 1'b0);
    rd_reg("r3_eq2", 3'd3, 32'd2);
    run_alu("eq", 4'h3, 3'd4, 3'd1, 3'd1, 32'd5, 32'd5, 32'd1, 1'b1);
    rd_reg("r7_ignored", 3'd7, 32'd0);
    run_alu("gt", 4'h4, 3'd5, 3'd2, 3'd1, 32'd3, 32'd5, 32'd0, 1'b0);
    rd_reg("r4_eq1", 3'd4, 32'd1);
    rd_reg("r5_eq0", 3'd5, 32'd0);
    run_alu("subneg", 4'h2, 3'd6, 3'd2, 3'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
    run_alu("gtsigned", 4'h4, 3'd7, 3'd1, 3'd6, 32'd5, 32'hFFFF_FFFE, 32'd1, 1'b0);
    rd_reg("r7_eq1", 3'd7, 32'd1);
    run_alu("and_r0", 4'h0, 3'd0, 3'd1, 3'd2, 32'd5, 32'd3, 32'd1, 1'b0);
    rd_reg("r0_alu_zero", 3'd0, 32'd0);
    run_alu("or", 4'h1, 3'd3, 3'd1, 3'd6, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
    rd_reg("r3_ones", 3'd3, 32'hFFFF_FFFF);

    // LI to R0: done pulses, R0 stays zero, ALU outputs hold last issue
    run_li("li_r0", 3'd0, 16'hFFFF);
    rd_reg("r0_li_zero", 3'd0, 32'd0);
    check("hold_f", 32'(alu_f), 32'd1);
    check("hold_a", alu_a, 32'd5);

    // Illegal op 9 targeting R1
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = mk(4'h9, 3'd1, 3'd1, 3'd2, 16'h7777);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_instr = '0;
    @(negedge clk);
    check("ill_err", 32'(err), 32'd1);
    check("ill_done", 32'(done), 32'd0);
    check("ill_rdy", 32'(in_ready), 32'd1);
    check("ill_f", 32'(alu_f), 32'd1);
    @(negedge clk);
    check("ill_err_off", 32'(err), 32'd0);
    check("ill_done2", 32'(done), 32'd0);
    rd_reg("ill_r1", 3'd1, 32'd5);

    // Reset during ISSUE of AND R6,R1,R2
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = mk(4'h0, 3'd6, 3'd1, 3'd2, 16'h0000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_instr = '0;
    @(negedge clk);
    check("abort_issue_a", alu_a, 32'd5);
    check("abort_issue_rdy", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_rst_done", 32'(done), 32'd0);
    check("abort_rst_a", alu_a, 32'd0);
    check("abort_rst_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_rel_rdy", 32'(in_ready), 32'd1);
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_no_done", 32'(dcnt), 32'd0);
    rd_reg("abort_r6", 3'd6, 32'd0);
    rd_reg("abort_r1", 3'd1, 32'd0);
    run_li("post_li", 3'd1, 16'h1234);
    rd_reg("post_r1", 3'd1, 32'h0000_1234);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
